// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit:
// request opcodes, FSM states and the divide-by-zero quotient.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_core_iter.sv
// One combinational step of the engine: shift-add multiply or
// restoring divide on the {acc, wrk} working pair.
module muldiv_core_iter #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] wrk_i,
    input  logic [WIDTH-1:0] opd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] wrk_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic           ge;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, opd_i};
        shl   = {acc_i, wrk_i[WIDTH-1]};
        ge    = shl >= {1'b0, opd_i};
        acc_o = acc_i;
        wrk_o = wrk_i;
        if (div_mode) begin
            // Quotient bits enter at the bottom as dividend bits leave the top.
            acc_o = ge ? WIDTH'(shl - {1'b0, opd_i}) : shl[WIDTH-1:0];
            wrk_o = {wrk_i[WIDTH-2:0], ge};
        end else if (wrk_i[0]) begin
            acc_o = sum[WIDTH:1];
            wrk_o = {sum[0], wrk_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[WIDTH-1:1]};
            wrk_o = {acc_i[0], wrk_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle MULT/DIV engine owning HI/LO; 33-cycle fixed latency,
// magnitude iteration with sign fix-up in a final cycle.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, opd_q, opd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, div0_q, div0_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic             done_q, done_d, dz_q, dz_d;

    logic [WIDTH-1:0]   acc_nx, wrk_nx, xa, ya, quot, rem;
    logic [2*WIDTH-1:0] prod;
    logic               sgn, xs, ys, is_md, op_div;

    muldiv_core_iter #(.WIDTH(WIDTH)) u_iter (
        .div_mode (is_div_q),
        .acc_i    (acc_q),
        .wrk_i    (wrk_q),
        .opd_i    (opd_q),
        .acc_o    (acc_nx),
        .wrk_o    (wrk_nx)
    );

    always_comb begin
        op_div = (op == OP_DIV) || (op == OP_DIVU);
        is_md  = op_div || (op == OP_MULT) || (op == OP_MULTU);
        sgn    = (op == OP_MULT) || (op == OP_DIV);
        xs     = sgn & x[WIDTH-1];
        ys     = sgn & y[WIDTH-1];
        xa     = xs ? -x : x;
        ya     = ys ? -y : y;
        prod   = neg_res_q ? -{acc_q, wrk_q} : {acc_q, wrk_q};
        quot   = neg_res_q ? -wrk_q : wrk_q;
        // Remainder follows the dividend; with y==0 this restores x.
        rem    = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        opd_d     = opd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            is_md: begin
                                is_div_d  = op_div;
                                div0_d    = op_div && (y == '0);
                                neg_res_d = xs ^ ys;
                                neg_rem_d = xs;
                                opd_d     = op_div ? ya : xa;
                                wrk_d     = op_div ? xa : ya;
                                acc_d     = '0;
                                cnt_d     = '0;
                                state_d   = S_CALC;
                            end
                            (op == OP_MTHI): hi_d = x;
                            (op == OP_MTLO): lo_d = x;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    acc_d = acc_nx;
                    wrk_d = wrk_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = div0_q ? '1 : quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                    dz_d    = is_div_q & div0_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            opd_q     <= opd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = state_q != S_IDLE;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Bench for muldiv_seq_unit: directed table, random ops against an
// arithmetic model, and flush/reset/busy-start sequences.
module tb_muldiv_seq_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  op;
    logic [31:0] x, y;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x, y, hi, lo;
        logic        dz;
    } vec_t;

    vec_t vt[10];

    muldiv_seq_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .x        (x),
        .y        (y),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o,
                                  input logic [31:0] a, b,
                                  output logic [31:0] h, l,
                                  output logic dz);
        longint p;
        int     q, r;
        h = '0; l = '0; dz = 1'b0; p = 0;
        if (o == OP_MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            h = p[63:32]; l = p[31:0];
        end else if (o == OP_MULTU) begin
            p = longint'({32'b0, a}) * longint'({32'b0, b});
            h = p[63:32]; l = p[31:0];
        end else if (b == 0) begin
            h = a; l = DIV0_QUOT; dz = 1'b1;
        end else if (o == OP_DIVU) begin
            l = a / b; h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000; h = 32'h0;
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            l = q; h = r;
        end
    endfunction

    // Entered and left at a negedge. poke>=0 drives an MTHI request at
    // that busy sample index; it must be ignored.
    task automatic run_md(input string tag, input logic [2:0] o,
                          input logic [31:0] a, b, eh, el,
                          input logic edz, input int poke);
        int n = 0;
        start = 1'b1; op = o; x = a; y = b;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (n == poke) begin
                start = 1'b1; op = OP_MTHI; x = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, n, 33);
        chk({tag, " done"}, done, 1);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        chk({tag, " div_zero"}, div_zero, edz);
        @(negedge clk);
        chk({tag, " done_clear"}, done, 0);
        chk({tag, " hi_hold"}, hi, eh);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, mh, ml;
        logic        mdz;
        logic        seen;

        vt[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vt[1] = '{OP_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vt[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vt[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vt[4] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vt[5] = '{OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vt[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vt[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vt[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vt[9] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = OP_NOP; x = '0; y = '0;
        repeat (2) @(negedge clk);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_md($sformatf("vec%0d", i), vt[i].op, vt[i].x, vt[i].y,
                   vt[i].hi, vt[i].lo, vt[i].dz, -1);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            model(ro, ra, rb, mh, ml, mdz);
            run_md($sformatf("rand%0d", i), ro, ra, rb, mh, ml, mdz, -1);
        end

        run_md("busy_mthi", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5);
        run_md("fix_mthi", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);

        start = 1'b1; op = OP_MTHI; x = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mthi hi", hi, 32'h1234);
        chk("mthi busy", busy, 0);
        chk("mthi done", done, 0);
        start = 1'b1; op = OP_MTLO; x = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo lo", lo, 32'h5678);

        start = 1'b1; op = OP_MTLO; x = 32'hFFFF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush lo", lo, 32'h5678);
        chk("idle_flush busy", busy, 0);

        start = 1'b1; op = OP_DIVU; x = 32'd100; y = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("flush pre busy", busy, 1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush hi", hi, 32'h1234);
        chk("flush lo", lo, 32'h5678);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || hi !== 32'h1234 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush no_done", seen, 0);

        start = 1'b1; op = OP_MULTU; x = 32'hFFFF_FFFF; y = 32'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset hi", hi, 0);
        chk("midreset lo", lo, 0);
        chk("midreset busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_md("post_reset", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Multi-cycle multiply/divide responder that owns the architectural HI/LO registers of the MIPS datapath.
- The core issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a start/busy handshake, and reads HI/LO (MFHI/MFLO) combinationally.
- Replaces single-cycle combinational multiply/divide with a 32-iteration shift-add / restoring-divide engine, so it does not limit clock frequency.
- The core stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request valid; sampled only when busy=0.
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- x  in  WIDTH  rs operand (multiplicand / dividend / MT source).
- y  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort in-flight operation (exception/branch squash).
- busy  out  1  engine iterating; core must stall MFHI/MFLO and new muldiv ops.
- done  out  1  one-cycle pulse in the cycle HI/LO first shows a new mult/div result.
- div_zero  out  1  sticky-per-op flag: last completed divide had y==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0 at posedge):
  - hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE.
  - Reset mid-operation aborts the operation; nothing is written to HI/LO except the zeroing.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op 1-4: latch operands. Signed ops store absolute values plus result/remainder sign bits.
  - Then clear the accumulator, set cnt=0, go to CALC; busy=1 from the next cycle.
  - op 5/6: hi<=x or lo<=x at that edge; busy stays 0; done not pulsed.
  - op 0/7: no effect.
- CALC:
  - One iteration per cycle, 32 cycles (cnt 0..31).
  - Multiply: radix-2 shift-add into a 64-bit {acc, mplr} register.
  - Divide: restoring; the remainder is shifted left with the next dividend bit; subtract the divisor if no borrow, quotient bit=1.
  - After cnt==31, go to FIX.
- FIX:
  - Apply sign correction:
    - MULT: negate the 64-bit product if signs differ.
    - DIV: quotient negative if signs differ; remainder takes the dividend sign.
  - Write {hi,lo}: product high/low, or hi=remainder, lo=quotient.
  - done=1 for this cycle only; busy=0 in the same cycle the new HI/LO is visible.
  - Return to IDLE.
- Latency: start accepted at edge N; busy high for edges N+1..N+33; HI/LO updated and done=1 after edge N+33.
  - Fixed latency of 33 cycles for all mult/div ops, including divide-by-zero.
- Divide by zero (y==0):
  - Runs the full latency.
  - Result lo=32'hFFFFFFFF, hi=x (unsigned dividend as given, unmodified for the signed case).
  - div_zero=1 until the next mult/div completes. No trap is raised.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): lo=32'h80000000, hi=0.
- start while busy=1: ignored, including MTHI/MTLO; the core guarantees a stall.
- flush:
  - While busy: go to IDLE next edge; busy=0; HI/LO unchanged; no done pulse.
  - In IDLE: flush has priority over start, so the request is dropped.
- Simultaneous FIX and start: start is ignored (busy is still 1 at that sample); a request may be accepted the following cycle.
- hi/lo change only at FIX, MTHI/MTLO, or reset.

Decomposition:
- Shared package (muldiv_pkg):
  - op encoding localparams OP_NOP..OP_MTLO.
  - State encoding IDLE/CALC/FIX.
  - Constant DIV0_QUOT=32'hFFFFFFFF.
- One natural sub-module: muldiv_core_iter (combinational single-step datapath).
  - Inputs: mode, acc, operand; outputs: next acc/quotient bits.
  - The top holds the FSM, counter, sign bookkeeping and HI/LO.

Test Plan:
- MULTU x=32'hFFFFFFFF, y=32'hFFFFFFFF -> after 33 busy cycles: hi=32'hFFFFFFFE, lo=32'h00000001, one done pulse.
- MULT x=-7 (32'hFFFFFFF9), y=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV x=-7, y=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU x=100, y=7 -> lo=14, hi=2, div_zero=0.
- DIVU x=5, y=0 -> lo=32'hFFFFFFFF, hi=5, div_zero=1.
  - Follow with MULTU 2*3 -> div_zero=0, lo=6.
- MTHI x=32'h1234 while idle -> hi=32'h1234 next cycle, busy stays 0.
  - Start DIVU and assert flush at cycle 10 -> busy=0 next cycle, hi still 32'h1234, no done.
  - Also assert rst_n=0 mid-CALC -> hi=lo=0, busy=0.
